// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port block RAM: round-robin grants,
// optional lock for atomic sequences, and a wait counter that breaks stale locks.
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int MAX_WAIT      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_req,
  input  logic                     a_lock,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic                     a_gnt,
  output logic                     a_rvalid,
  output logic [DATA_WIDTH-1:0]    a_rdata,
  input  logic                     b_req,
  input  logic                     b_lock,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  output logic                     b_gnt,
  output logic                     b_rvalid,
  output logic [DATA_WIDTH-1:0]    b_rdata,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic [1:0]               owner
);

  // State encoding doubles as the owner output value.
  typedef enum logic [1:0] {
    FREE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;   // 0 = A, 1 = B
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       a_rvalid_q, b_rvalid_q;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst) begin
      unique case (state_q)
        FREE: begin
          if (a_req && (!b_req || last_gnt_q)) a_gnt = 1'b1;
          else if (b_req)                      b_gnt = 1'b1;
        end
        OWN_A: begin
          if (b_req && wait_cnt_q == MAX_WAIT_C) b_gnt = 1'b1;
          else                                   a_gnt = a_req;
        end
        OWN_B: begin
          if (a_req && wait_cnt_q == MAX_WAIT_C) a_gnt = 1'b1;
          else                                   b_gnt = b_req;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (a_gnt) begin
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end else if (b_gnt) begin
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end
  end

  // Any grant decides the next owner from its own lock bit, which also
  // covers a lock being broken by the waiting port.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    if (a_gnt) begin
      last_gnt_d = 1'b0;
      state_d    = a_lock ? OWN_A : FREE;
    end else if (b_gnt) begin
      last_gnt_d = 1'b1;
      state_d    = b_lock ? OWN_B : FREE;
    end else if (state_q == OWN_A && !a_req && !a_lock) begin
      state_d = FREE;
    end else if (state_q == OWN_B && !b_req && !b_lock) begin
      state_d = FREE;
    end

    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_WAIT_C &&
                 ((state_q == OWN_A && b_req && !b_gnt) ||
                  (state_q == OWN_B && a_req && !a_gnt))) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FREE;
      last_gnt_q <= 1'b1;
      wait_cnt_q <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      wait_cnt_q <= wait_cnt_d;
      a_rvalid_q <= a_gnt & ~a_we;
      b_rvalid_q <= b_gnt & ~b_we;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = ram_rdata;
  assign b_rdata  = ram_rdata;
  assign owner    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a behavioural RAM, a rule-level model
// of the arbiter checked every cycle, and literal checks on key cycles.
module tb_mem_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 10;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_lock, a_we, b_req, b_lock, b_we;
  logic [AW-1:0] a_addr, b_addr, ram_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_wdata, ram_rdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we;
  logic [1:0]    owner;

  int n_vec  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read.
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Model state: owner 0/1/2, last winner, wait count, pending read results.
  int            m_own, m_wait;
  bit            m_last_b, m_rva, m_rvb;
  logic [DW-1:0] m_da, m_db;
  logic [DW-1:0] shadow [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own    = 0;
    m_last_b = 1'b1;
    m_wait   = 0;
    m_rva    = 1'b0;
    m_rvb    = 1'b0;
  endtask

  task automatic model_cycle();
    int            win, nxt;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    if (!rst) begin
      model_reset();
      chk("m_rst_a_gnt", 32'(a_gnt), 0);
      chk("m_rst_b_gnt", 32'(b_gnt), 0);
      chk("m_rst_ram_we", 32'(ram_we), 0);
      chk("m_rst_ram_addr", 32'(ram_addr), 0);
      chk("m_rst_ram_wdata", 32'(ram_wdata), 0);
      chk("m_rst_owner", 32'(owner), 0);
      chk("m_rst_a_rvalid", 32'(a_rvalid), 0);
      chk("m_rst_b_rvalid", 32'(b_rvalid), 0);
      return;
    end
    chk("m_a_rvalid", 32'(a_rvalid), 32'(m_rva));
    chk("m_b_rvalid", 32'(b_rvalid), 32'(m_rvb));
    if (m_rva) chk("m_a_rdata", 32'(a_rdata), 32'(m_da));
    if (m_rvb) chk("m_b_rdata", 32'(b_rdata), 32'(m_db));
    chk("m_owner", 32'(owner), 32'(m_own));

    if (m_own == 0)      win = (a_req && b_req) ? (m_last_b ? 1 : 2) : a_req ? 1 : b_req ? 2 : 0;
    else if (m_own == 1) win = (b_req && m_wait == MW) ? 2 : (a_req ? 1 : 0);
    else                 win = (a_req && m_wait == MW) ? 1 : (b_req ? 2 : 0);

    e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (win == 1) begin e_we = a_we; e_addr = a_addr; e_wd = a_wdata; end
    if (win == 2) begin e_we = b_we; e_addr = b_addr; e_wd = b_wdata; end
    chk("m_a_gnt", 32'(a_gnt), 32'(win == 1));
    chk("m_b_gnt", 32'(b_gnt), 32'(win == 2));
    chk("m_ram_we", 32'(ram_we), 32'(e_we));
    chk("m_ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("m_ram_wdata", 32'(ram_wdata), 32'(e_wd));

    m_rva = (win == 1) && !a_we;
    m_rvb = (win == 2) && !b_we;
    if (m_rva) m_da = shadow[a_addr];
    if (m_rvb) m_db = shadow[b_addr];
    if (win != 0 && e_we) shadow[e_addr] = e_wd;

    nxt = m_own;
    if (win != 0) begin
      m_last_b = (win == 2);
      nxt = ((win == 1) ? a_lock : b_lock) ? win : 0;
    end else if (m_own == 1 && !a_lock) nxt = 0;
    else if (m_own == 2 && !b_lock) nxt = 0;

    if (nxt != m_own) m_wait = 0;
    else if ((m_own == 1 && b_req && win != 2) || (m_own == 2 && a_req && win != 1))
      m_wait = (m_wait < MW) ? m_wait + 1 : m_wait;
    m_own = nxt;
  endtask

  task automatic drv_a(input bit req, input bit lock, input bit we, input int addr, input int wd);
    a_req = req; a_lock = lock; a_we = we; a_addr = addr[AW-1:0]; a_wdata = wd[DW-1:0];
  endtask

  task automatic drv_b(input bit req, input bit lock, input bit we, input int addr, input int wd);
    b_req = req; b_lock = lock; b_we = we; b_addr = addr[AW-1:0]; b_wdata = wd[DW-1:0];
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    at_neg();
    to_next();
  endtask

  initial begin
    rst = 1'b0;
    drv_a(1, 0, 0, 0, 0);
    drv_b(1, 0, 0, 0, 0);
    model_reset();
    // reset held with both requesting
    at_neg();
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_b_gnt", 32'(b_gnt), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_owner", 32'(owner), 0);
    to_next();
    at_neg();
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_b_rvalid", 32'(b_rvalid), 0);
    to_next();
    rst = 1'b1;

    // first tie goes to A; B preloads 51 and then address 1
    drv_a(1, 0, 1, 50, 5);
    drv_b(1, 0, 1, 51, 10);
    at_neg();
    chk("tie_a_gnt", 32'(a_gnt), 1);
    chk("tie_b_gnt", 32'(b_gnt), 0);
    chk("tie_ram_addr", 32'(ram_addr), 50);
    to_next();
    drv_a(0, 0, 0, 0, 0);
    at_neg();
    chk("preload_b_gnt", 32'(b_gnt), 1);
    to_next();
    drv_b(1, 0, 1, 1, 'h133);
    step();
    drv_b(0, 0, 0, 0, 0);
    drv_a(1, 0, 0, 1, 0);
    step();
    drv_a(0, 0, 0, 0, 0);
    at_neg();
    chk("wr_rd_a_rvalid", 32'(a_rvalid), 1);
    chk("wr_rd_a_rdata", 32'(a_rdata), 'h133);
    to_next();

    // round robin: last winner was A, so B leads
    drv_a(1, 0, 0, 50, 0);
    drv_b(1, 0, 0, 51, 0);
    at_neg();
    chk("rr1_b_gnt", 32'(b_gnt), 1);
    to_next();
    at_neg();
    chk("rr2_a_gnt", 32'(a_gnt), 1);
    chk("rr2_b_rdata", 32'(b_rdata), 10);
    to_next();
    at_neg();
    chk("rr3_b_gnt", 32'(b_gnt), 1);
    chk("rr3_a_rvalid", 32'(a_rvalid), 1);
    chk("rr3_a_rdata", 32'(a_rdata), 5);
    to_next();
    at_neg();
    chk("rr4_a_gnt", 32'(a_gnt), 1);
    to_next();
    drv_a(0, 0, 0, 0, 0);
    step();

    // lock: A read 50 locked, then write 52 releasing, B waiting throughout
    drv_a(1, 1, 0, 50, 0);
    at_neg();
    chk("lock1_a_gnt", 32'(a_gnt), 1);
    to_next();
    drv_a(1, 0, 1, 52, 'h2AA);
    at_neg();
    chk("lock2_owner", 32'(owner), 1);
    chk("lock2_b_gnt", 32'(b_gnt), 0);
    chk("lock2_a_gnt", 32'(a_gnt), 1);
    chk("lock2_a_rdata", 32'(a_rdata), 5);
    to_next();
    drv_a(0, 0, 0, 0, 0);
    at_neg();
    chk("lock3_owner", 32'(owner), 0);
    chk("lock3_b_gnt", 32'(b_gnt), 1);
    to_next();
    drv_b(0, 0, 0, 0, 0);
    step();

    // starvation: A re-reads under lock, B waits MAX_WAIT cycles then wins
    drv_a(1, 1, 0, 52, 0);
    step();
    drv_b(1, 0, 0, 52, 0);
    for (int i = 0; i < MW; i++) begin
      at_neg();
      chk("starve_wait_b_gnt", 32'(b_gnt), 0);
      to_next();
    end
    at_neg();
    chk("starve_b_gnt", 32'(b_gnt), 1);
    chk("starve_a_gnt", 32'(a_gnt), 0);
    chk("starve_owner_before", 32'(owner), 1);
    to_next();
    drv_b(0, 0, 0, 0, 0);
    drv_a(1, 0, 0, 52, 0);
    at_neg();
    chk("starve_owner_after", 32'(owner), 0);
    chk("starve_a_retry", 32'(a_gnt), 1);
    chk("starve_b_rdata", 32'(b_rdata), 'h2AA);
    to_next();
    drv_a(0, 0, 0, 0, 0);
    step();

    // async reset while B holds the lock with a read in flight
    drv_b(1, 1, 0, 50, 0);
    step();
    at_neg();
    chk("arst_owner_before", 32'(owner), 2);
    chk("arst_b_gnt_before", 32'(b_gnt), 1);
    #1;
    drv_b(0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_owner", 32'(owner), 0);
    chk("arst_b_gnt", 32'(b_gnt), 0);
    #1;
    rst = 1'b1;
    to_next();
    at_neg();
    chk("arst_b_rvalid", 32'(b_rvalid), 0);
    to_next();

    // owner drops request and lock: released with no access
    drv_a(1, 1, 0, 50, 0);
    step();
    drv_a(0, 0, 0, 0, 0);
    at_neg();
    chk("rel_owner_before", 32'(owner), 1);
    chk("rel_a_gnt", 32'(a_gnt), 0);
    to_next();
    at_neg();
    chk("rel_owner_after", 32'(owner), 0);
    to_next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
